// File: rtl/apb_vga_master_if.sv
// Command/response stream and APB3 bus bundle for the apb_vga_master initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface apb_vga_master_if #(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int APB_DATA_WIDTH = 32
);
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic                      req_write_i;
  logic [APB_ADDR_WIDTH-1:0] req_addr_i;
  logic [APB_DATA_WIDTH-1:0] req_wdata_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_o;
  logic                      rsp_err_o;
  logic [APB_ADDR_WIDTH-1:0] apb_paddr_o;
  logic [APB_DATA_WIDTH-1:0] apb_pwdata_o;
  logic                      apb_pwrite_o;
  logic                      apb_psel_o;
  logic                      apb_penable_o;
  logic [APB_DATA_WIDTH-1:0] apb_prdata_i;
  logic                      apb_pready_i;
  logic                      apb_pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  apb_prdata_i, apb_pready_i, apb_pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output apb_prdata_i, apb_pready_i, apb_pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o
  );
endinterface

// File: rtl/apb_vga_master.sv
// APB3 initiator turning a valid/ready command stream into single transfers toward
// the VGA character generator, with wait-state timeout and a held response.
module apb_vga_master #(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  apb_vga_master_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      req_ready_q, req_ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      accept_s;

  assign accept_s = bus.req_valid_i & req_ready_q;

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          req_ready_d = 1'b0;
          if (bus.req_addr_i[1:0] != 2'b00) begin
            // Misaligned: answer with an error and never touch the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = bus.req_addr_i;
            pwdata_d = bus.req_wdata_i;
            pwrite_d = bus.req_write_i;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (bus.apb_pready_i) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.apb_pslverr_i;
          if (pwrite_q || bus.apb_pslverr_i) begin
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = bus.apb_prdata_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
        end else begin
          req_ready_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.apb_paddr_o   = paddr_q;
  assign bus.apb_pwdata_o  = pwdata_q;
  assign bus.apb_pwrite_o  = pwrite_q;
  assign bus.apb_psel_o    = psel_q;
  assign bus.apb_penable_o = penable_q;

endmodule

// File: tb/tb_apb_vga_master.sv
// Directed bench for apb_vga_master with a small configurable APB slave model.
module tb_apb_vga_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  int          ws        = 2;
  logic        force_en  = 1'b0;
  logic        force_val = 1'b0;
  logic        err_cfg   = 1'b0;
  logic [31:0] rdata_cfg = 32'h0;
  int          acc_cnt   = 0;

  apb_vga_master_if #(.APB_ADDR_WIDTH(14), .APB_DATA_WIDTH(32)) bus ();

  apb_vga_master #(.APB_ADDR_WIDTH(14), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Slave model: pready after ws wait states in ACCESS, or forced by the test.
  always @(posedge clk) begin
    if (bus.apb_psel_o && bus.apb_penable_o) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign bus.apb_pready_i  = force_en ? force_val
                           : (bus.apb_psel_o && bus.apb_penable_o && (acc_cnt >= ws));
  assign bus.apb_pslverr_i = err_cfg & bus.apb_pready_i;
  assign bus.apb_prdata_i  = rdata_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and stop on the first cycle rsp_valid is seen; lat counts the accept cycle as 1.
  task automatic run_xfer(input logic w, input logic [13:0] a, input logic [31:0] d,
                          output int lat, output int nsel, output int nen);
    chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = w;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    tick();
    bus.req_valid_i = 1'b0;
    lat  = 1;
    nsel = 0;
    nen  = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid_o) break;
      if (bus.apb_psel_o) begin
        nsel++;
        chk("paddr", 32'(bus.apb_paddr_o), 32'(a));
        chk("pwrite", 32'(bus.apb_pwrite_o), 32'(w));
        chk("pwdata", bus.apb_pwdata_o, d);
      end
      if (bus.apb_penable_o) nen++;
      tick();
      lat++;
    end
    chk("rsp_seen", 32'(bus.rsp_valid_o), 32'd1);
  endtask

  task automatic handshake();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("hs_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("hs_req_ready", 32'(bus.req_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, nsel, nen;
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 14'h0;
    bus.req_wdata_i = 32'h0;
    bus.rsp_ready_i = 1'b0;

    tick();
    tick();
    chk("rst_psel", 32'(bus.apb_psel_o), 32'd0);
    chk("rst_penable", 32'(bus.apb_penable_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_paddr", 32'(bus.apb_paddr_o), 32'h0);
    chk("rst_pwdata", bus.apb_pwdata_o, 32'h0);
    chk("rst_pwrite", 32'(bus.apb_pwrite_o), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    rst = 1'b0;
    tick();

    // vgachargen-style write: two wait states
    ws = 2; rdata_cfg = 32'h55AA_55AA;
    run_xfer(1'b1, 14'h0010, 32'h0000_1241, lat, nsel, nen);
    chk("wr_lat", 32'(lat), 32'd5);
    chk("wr_psel_cycles", 32'(nsel), 32'd4);
    chk("wr_penable_cycles", 32'(nen), 32'd3);
    chk("wr_err", 32'(bus.rsp_err_o), 32'd0);
    chk("wr_rdata", bus.rsp_rdata_o, 32'h0);
    chk("wr_req_ready", 32'(bus.req_ready_o), 32'd0);
    handshake();

    // zero-wait read
    ws = 0; rdata_cfg = 32'hDEAD_BEEF;
    run_xfer(1'b0, 14'h2580, 32'h0000_0000, lat, nsel, nen);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_psel_cycles", 32'(nsel), 32'd2);
    chk("rd_penable_cycles", 32'(nen), 32'd1);
    chk("rd_rdata", bus.rsp_rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", 32'(bus.rsp_err_o), 32'd0);
    handshake();

    // timeout with pready held low, then a late pready pulse
    force_en = 1'b1; force_val = 1'b0; rdata_cfg = 32'h1111_2222;
    run_xfer(1'b0, 14'h0100, 32'h0, lat, nsel, nen);
    chk("to_penable_cycles", 32'(nen), 32'd16);
    chk("to_psel_cycles", 32'(nsel), 32'd17);
    chk("to_lat", 32'(lat), 32'd18);
    chk("to_psel_after", 32'(bus.apb_psel_o), 32'd0);
    chk("to_err", 32'(bus.rsp_err_o), 32'd1);
    chk("to_rdata", bus.rsp_rdata_o, 32'h0);
    force_val = 1'b1;
    tick();
    force_val = 1'b0;
    tick();
    chk("late_psel", 32'(bus.apb_psel_o), 32'd0);
    chk("late_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("late_err", 32'(bus.rsp_err_o), 32'd1);
    chk("late_rdata", bus.rsp_rdata_o, 32'h0);
    force_en = 1'b0;
    handshake();

    // misaligned address
    ws = 2;
    run_xfer(1'b1, 14'h0013, 32'hCAFE_0001, lat, nsel, nen);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_psel_cycles", 32'(nsel), 32'd0);
    chk("mis_psel_now", 32'(bus.apb_psel_o), 32'd0);
    chk("mis_err", 32'(bus.rsp_err_o), 32'd1);
    chk("mis_rdata", bus.rsp_rdata_o, 32'h0);
    handshake();
    chk("mis_psel_after", 32'(bus.apb_psel_o), 32'd0);

    // slave error plus response backpressure with a queued command
    ws = 0; err_cfg = 1'b1;
    run_xfer(1'b1, 14'h0020, 32'h0BAD_0BAD, lat, nsel, nen);
    chk("bp_lat", 32'(lat), 32'd3);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 14'h0040;
    bus.req_wdata_i = 32'h0000_A5A5;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("bp_err", 32'(bus.rsp_err_o), 32'd1);
      chk("bp_rdata", bus.rsp_rdata_o, 32'h0);
      chk("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      chk("bp_psel", 32'(bus.apb_psel_o), 32'd0);
      tick();
    end
    err_cfg = 1'b0; ws = 2;
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("bp_hs_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("bp_hs_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("bp_not_yet_sel", 32'(bus.apb_psel_o), 32'd0);
    tick();
    bus.req_valid_i = 1'b0;
    chk("q_psel", 32'(bus.apb_psel_o), 32'd1);
    chk("q_penable", 32'(bus.apb_penable_o), 32'd0);
    chk("q_paddr", 32'(bus.apb_paddr_o), 32'h0040);
    chk("q_req_ready", 32'(bus.req_ready_o), 32'd0);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid_o) break;
      tick();
      lat++;
    end
    chk("q_lat", 32'(lat), 32'd5);
    chk("q_err", 32'(bus.rsp_err_o), 32'd0);
    handshake();

    // reset on the second ACCESS cycle
    ws = 2;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 14'h0030;
    bus.req_wdata_i = 32'h0000_7777;
    tick();
    bus.req_valid_i = 1'b0;
    chk("rs_setup_psel", 32'(bus.apb_psel_o), 32'd1);
    tick();
    chk("rs_acc1_penable", 32'(bus.apb_penable_o), 32'd1);
    tick();
    chk("rs_acc2_penable", 32'(bus.apb_penable_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_psel", 32'(bus.apb_psel_o), 32'd0);
    chk("rs_penable", 32'(bus.apb_penable_o), 32'd0);
    chk("rs_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rs_req_ready", 32'(bus.req_ready_o), 32'd1);
    tick();
    run_xfer(1'b1, 14'h0034, 32'h00C0_FFEE, lat, nsel, nen);
    chk("post_lat", 32'(lat), 32'd5);
    chk("post_psel_cycles", 32'(nsel), 32'd4);
    chk("post_err", 32'(bus.rsp_err_o), 32'd0);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
